// File: rtl/uart_pkg.sv
// uart_pkg: shared UART register map and Tx sequencer state encoding
package uart_pkg;
  typedef enum logic [2:0] {SMIdle, SMLoad, SMGo, SMPollRd, SMPollChk, SMClear} SeqState;
  localparam int ADDR_CTL = 0;
  localparam int ADDR_RX = 1;
  localparam int ADDR_TX = 2;
  localparam int CTL_TX_CMP_BIT = 1;
  localparam int CTL_TX_GO_BIT = 2;
  localparam logic [7:0] CTL_GO = 8'(1 << CTL_TX_GO_BIT);
  localparam logic [7:0] CTL_CLR = 8'h00;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: small circular FIFO with combinational head read, shared by Tx and Rx paths
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign data_o = mem_q[rd_ptr_q];
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: streams FIFO'd bytes into UART_Component via the register-level Tx workflow
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          ADDR_W       = 3,
  parameter logic [15:0] POLL_TIMEOUT = 16'd4095
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wr_o,
  output logic              rd_o,
  output logic [7:0]        data_o,
  input  logic [7:0]        data_i,
  output logic              idle_o,
  output logic              error_o,
  output logic [15:0]       sent_count_o
);
  SeqState state_q, state_d;
  logic wr_q, wr_d, rd_q, rd_d, error_q, error_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] data_q, data_d, fifo_data;
  logic [15:0] poll_q, poll_d, sent_count_q, sent_count_d;
  logic fifo_pop, fifo_full, fifo_empty;
  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (byte_valid_i),
    .pop_i   (fifo_pop),
    .data_i  (byte_i),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  assign byte_ready_o = !fifo_full;
  assign idle_o = (state_q == SMIdle) && fifo_empty;
  assign addr_o = addr_q;
  assign wr_o = wr_q;
  assign rd_o = rd_q;
  assign data_o = data_q;
  assign error_o = error_q;
  assign sent_count_o = sent_count_q;
  // Strobes are decided one state ahead so each is registered and lines up with its state's cycle.
  always_comb begin
    state_d = state_q;
    wr_d = 1'b0;
    rd_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    poll_d = poll_q;
    error_d = error_q;
    sent_count_d = sent_count_q;
    fifo_pop = 1'b0;
    case (state_q)
      SMIdle: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_d = SMLoad;
        wr_d = 1'b1;
        addr_d = ADDR_W'(ADDR_TX);
        data_d = fifo_data;
      end
      SMLoad: begin
        state_d = SMGo;
        wr_d = 1'b1;
        addr_d = ADDR_W'(ADDR_CTL);
        data_d = CTL_GO;
      end
      SMGo: begin
        state_d = SMPollRd;
        rd_d = 1'b1;
        addr_d = ADDR_W'(ADDR_CTL);
        poll_d = '0;
      end
      SMPollRd: state_d = SMPollChk;
      SMPollChk: begin
        if (data_i[CTL_TX_CMP_BIT] || poll_q == POLL_TIMEOUT) begin
          state_d = SMClear;
          wr_d = 1'b1;
          addr_d = ADDR_W'(ADDR_CTL);
          data_d = CTL_CLR;
          sent_count_d = data_i[CTL_TX_CMP_BIT] ? sent_count_q + 16'd1 : sent_count_q;
          error_d = error_q || !data_i[CTL_TX_CMP_BIT];
        end else begin
          state_d = SMPollRd;
          rd_d = 1'b1;
          poll_d = poll_q + 16'd1;
        end
      end
      SMClear: state_d = SMIdle;
      default: state_d = SMIdle;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SMIdle;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      poll_q <= '0;
      error_q <= 1'b0;
      sent_count_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      addr_q <= addr_d;
      data_q <= data_d;
      poll_q <= poll_d;
      error_q <= error_d;
      sent_count_q <= sent_count_d;
    end
  end
  a_state_legal: assert property (@(posedge clock) disable iff (!reset)
    state_q inside {SMIdle, SMLoad, SMGo, SMPollRd, SMPollChk, SMClear})
    else $error("uart_tx_sequencer: illegal state %0d", state_q);
endmodule
